// File: rtl/wb_pkg.sv
// Shared widths and the load-queue entry type for the writeback arbiter.
// The WB_BYPASS_EN macro (see wb_arbiter) does not affect anything here.
package wb_pkg;

   localparam int XLEN     = 32;
   localparam int REG_AW   = 5;
   localparam int LQ_DEPTH = 2;
   localparam int LQ_PW    = (LQ_DEPTH > 1) ? $clog2(LQ_DEPTH) : 1;
   localparam int LQ_CW    = $clog2(LQ_DEPTH) + 1;
   localparam int NREG     = 1 << REG_AW;

   typedef struct packed {
      logic [REG_AW-1:0] rd;
      logic [XLEN-1:0]   data;
   } lq_entry_t;

endpackage

// File: rtl/wb_load_queue.sv
// Small FIFO holding returned loads until the register file write port is free.
// Acceptance depends only on the registered occupancy, so a full queue refuses a push even while popping.
import wb_pkg::*;

module wb_load_queue (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             push_req,
   input  lq_entry_t        push_entry,
   input  logic             pop,
   output logic             ready,
   output logic             empty,
   output lq_entry_t        head,
   output logic [LQ_CW-1:0] count
);

   lq_entry_t        mem [LQ_DEPTH];
   logic [LQ_PW-1:0] wr_ptr_p1;
   logic [LQ_PW-1:0] rd_ptr_p1;
   logic [LQ_CW-1:0] count_p1;
   logic             push;
   logic             pop_ok;

   assign ready  = (count_p1 < LQ_CW'(LQ_DEPTH));
   assign empty  = (count_p1 == '0);
   assign push   = push_req & ready;
   assign pop_ok = pop & ~empty;
   assign head   = mem[rd_ptr_p1];
   assign count  = count_p1;

   // pointer/occupancy stage
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         wr_ptr_p1 <= '0;
         rd_ptr_p1 <= '0;
         count_p1  <= '0;
      end else begin
         if (push)
            wr_ptr_p1 <= (wr_ptr_p1 == LQ_PW'(LQ_DEPTH - 1)) ? '0 : wr_ptr_p1 + 1'b1;
         if (pop_ok)
            rd_ptr_p1 <= (rd_ptr_p1 == LQ_PW'(LQ_DEPTH - 1)) ? '0 : rd_ptr_p1 + 1'b1;
         case ({push, pop_ok})
            2'b10:   count_p1 <= count_p1 + 1'b1;
            2'b01:   count_p1 <= count_p1 - 1'b1;
            default: count_p1 <= count_p1;
         endcase
      end
   end

   // entry storage, data only, no reset needed
   always_ff @(posedge CLK) begin
      if (push)
         mem[wr_ptr_p1] <= push_entry;
   end

endmodule

// File: rtl/wb_arbiter.sv
// Register-file writeback arbiter: ALU results take priority, loads drain from a queue, plus load scoreboard.
// Define WB_BYPASS_EN to drive FWD_A/FWD_B from the registered write port; otherwise they are tied low.
import wb_pkg::*;

module wb_arbiter (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              ALU_VALID,
   input  logic [REG_AW-1:0] ALU_RD,
   input  logic [XLEN-1:0]   ALU_D,
   input  logic              LD_ISSUE,
   input  logic [REG_AW-1:0] LD_ISSUE_RD,
   input  logic              LD_VALID,
   input  logic [REG_AW-1:0] LD_RD,
   input  logic [XLEN-1:0]   LD_D,
   output logic              LD_READY,
   output logic              WE,
   output logic [REG_AW-1:0] AW,
   output logic [XLEN-1:0]   D,
   input  logic [REG_AW-1:0] AR,
   input  logic [REG_AW-1:0] BR,
   output logic              BUSY_A,
   output logic              BUSY_B,
   output logic              FWD_A,
   output logic              FWD_B,
   output logic [LQ_CW-1:0]  QCOUNT
);

   lq_entry_t         push_entry;
   lq_entry_t         head;
   logic              q_empty;
   logic              alu_wr;
   logic              pop;
   logic              we_p1;
   logic [REG_AW-1:0] aw_p1;
   logic [XLEN-1:0]   d_p1;
   logic [NREG-1:1]   busy_p1;
   logic [NREG-1:0]   busy_all;
   logic [NREG-1:1]   busy_set;
   logic [NREG-1:1]   busy_clr;

   assign push_entry.rd   = LD_RD;
   assign push_entry.data = LD_D;

   wb_load_queue u_lq (
      .CLK        (CLK),
      .RST_N      (RST_N),
      .push_req   (LD_VALID),
      .push_entry (push_entry),
      .pop        (pop),
      .ready      (LD_READY),
      .empty      (q_empty),
      .head       (head),
      .count      (QCOUNT)
   );

   // A write to r0 is not a write, so it leaves the port free for the queue.
   assign alu_wr = ALU_VALID & (ALU_RD != '0);
   assign pop    = ~alu_wr & ~q_empty;

   // write-port stage
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         we_p1 <= 1'b0;
         aw_p1 <= '0;
         d_p1  <= '0;
      end else if (alu_wr) begin
         we_p1 <= 1'b1;
         aw_p1 <= ALU_RD;
         d_p1  <= ALU_D;
      end else if (pop && head.rd != '0) begin
         we_p1 <= 1'b1;
         aw_p1 <= head.rd;
         d_p1  <= head.data;
      end else begin
         we_p1 <= 1'b0;
      end
   end

   assign WE = we_p1;
   assign AW = aw_p1;
   assign D  = d_p1;

   // Clear is applied before set so a same-edge reissue of that rd stays busy.
   always_comb begin
      busy_set = '0;
      busy_clr = '0;
      if (LD_ISSUE && LD_ISSUE_RD != '0)
         busy_set[LD_ISSUE_RD] = 1'b1;
      if (pop && head.rd != '0)
         busy_clr[head.rd] = 1'b1;
   end

   // scoreboard stage
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N)
         busy_p1 <= '0;
      else
         busy_p1 <= (busy_p1 & ~busy_clr) | busy_set;
   end

   assign busy_all = {busy_p1, 1'b0};
   assign BUSY_A   = busy_all[AR];
   assign BUSY_B   = busy_all[BR];

`ifdef WB_BYPASS_EN
   assign FWD_A = we_p1 & (aw_p1 == AR) & (aw_p1 != '0);
   assign FWD_B = we_p1 & (aw_p1 == BR) & (aw_p1 != '0);
`else
   assign FWD_A = 1'b0;
   assign FWD_B = 1'b0;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter; FWD expectations follow WB_BYPASS_EN.
`timescale 1ns/1ps
module tb_wb_arbiter;
   import wb_pkg::*;

   logic              CLK = 1'b0;
   logic              RST_N;
   logic              ALU_VALID;
   logic [REG_AW-1:0] ALU_RD;
   logic [XLEN-1:0]   ALU_D;
   logic              LD_ISSUE;
   logic [REG_AW-1:0] LD_ISSUE_RD;
   logic              LD_VALID;
   logic [REG_AW-1:0] LD_RD;
   logic [XLEN-1:0]   LD_D;
   logic              LD_READY;
   logic              WE;
   logic [REG_AW-1:0] AW;
   logic [XLEN-1:0]   D;
   logic [REG_AW-1:0] AR;
   logic [REG_AW-1:0] BR;
   logic              BUSY_A;
   logic              BUSY_B;
   logic              FWD_A;
   logic              FWD_B;
   logic [LQ_CW-1:0]  QCOUNT;

   int errors = 0;
   int checks = 0;
   logic exp_fwd;

   wb_arbiter dut (
      .CLK(CLK), .RST_N(RST_N),
      .ALU_VALID(ALU_VALID), .ALU_RD(ALU_RD), .ALU_D(ALU_D),
      .LD_ISSUE(LD_ISSUE), .LD_ISSUE_RD(LD_ISSUE_RD),
      .LD_VALID(LD_VALID), .LD_RD(LD_RD), .LD_D(LD_D), .LD_READY(LD_READY),
      .WE(WE), .AW(AW), .D(D),
      .AR(AR), .BR(BR), .BUSY_A(BUSY_A), .BUSY_B(BUSY_B),
      .FWD_A(FWD_A), .FWD_B(FWD_B), .QCOUNT(QCOUNT)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk_wr(input string tag, input logic we, input logic [REG_AW-1:0] aw,
                         input logic [XLEN-1:0] d);
      chk({tag, ".WE"}, 64'(WE), 64'(we));
      chk({tag, ".AW"}, 64'(AW), 64'(aw));
      chk({tag, ".D"},  64'(D),  64'(d));
   endtask

   initial begin
`ifdef WB_BYPASS_EN
      exp_fwd = 1'b1;
`else
      exp_fwd = 1'b0;
`endif
      RST_N = 1'b0; ALU_VALID = 0; ALU_RD = 0; ALU_D = 0;
      LD_ISSUE = 0; LD_ISSUE_RD = 0; LD_VALID = 0; LD_RD = 0; LD_D = 0;
      AR = 5'd9; BR = 5'd8;
      tick(); tick();
      RST_N = 1'b1;
      tick();
      chk_wr("reset", 1'b0, 5'd0, 32'h0);
      chk("reset.QCOUNT", 64'(QCOUNT), 64'd0);
      chk("reset.LD_READY", 64'(LD_READY), 64'd1);
      chk("reset.BUSY_A", 64'(BUSY_A), 64'd0);

      // ALU write, then ALU to r0 counts as idle
      ALU_VALID = 1; ALU_RD = 5'd5; ALU_D = 32'hDEADBEEF;
      tick();
      chk_wr("alu5", 1'b1, 5'd5, 32'hDEADBEEF);
      ALU_RD = 5'd0; ALU_D = 32'h11111111;
      tick();
      chk_wr("alu0", 1'b0, 5'd5, 32'hDEADBEEF);

      // load held behind three ALU writes
      ALU_RD = 5'd3; ALU_D = 32'hA;
      LD_VALID = 1; LD_RD = 5'd7; LD_D = 32'h00001234;
      tick();
      LD_VALID = 0;
      chk_wr("hold.c0", 1'b1, 5'd3, 32'hA);
      chk("hold.c0.QCOUNT", 64'(QCOUNT), 64'd1);
      ALU_D = 32'hB;
      tick();
      chk("hold.c1.QCOUNT", 64'(QCOUNT), 64'd1);
      ALU_D = 32'hC;
      tick();
      chk_wr("hold.c2", 1'b1, 5'd3, 32'hC);
      chk("hold.c2.QCOUNT", 64'(QCOUNT), 64'd1);
      ALU_VALID = 0;
      tick();
      chk_wr("hold.drain", 1'b1, 5'd7, 32'h00001234);
      chk("hold.drain.QCOUNT", 64'(QCOUNT), 64'd0);
      tick();
      chk("hold.idle.WE", 64'(WE), 64'd0);

      // three back-to-back returns against a busy ALU
      ALU_VALID = 1; ALU_RD = 5'd3; ALU_D = 32'hF0;
      LD_VALID = 1; LD_RD = 5'd10; LD_D = 32'hA1;
      tick();
      chk("full.q1", 64'(QCOUNT), 64'd1);
      chk("full.rdy1", 64'(LD_READY), 64'd1);
      LD_RD = 5'd11; LD_D = 32'hA2;
      tick();
      chk("full.q2", 64'(QCOUNT), 64'd2);
      chk("full.rdy2", 64'(LD_READY), 64'd0);
      LD_RD = 5'd12; LD_D = 32'hA3;
      tick();
      chk("full.stall.q", 64'(QCOUNT), 64'd2);
      ALU_VALID = 0;
      tick();
      chk_wr("full.pop10", 1'b1, 5'd10, 32'hA1);
      chk("full.pop10.q", 64'(QCOUNT), 64'd1);
      chk("full.pop10.rdy", 64'(LD_READY), 64'd1);
      tick();
      LD_VALID = 0;
      chk_wr("full.pop11", 1'b1, 5'd11, 32'hA2);
      chk("full.pop11.q", 64'(QCOUNT), 64'd1);
      tick();
      chk_wr("full.pop12", 1'b1, 5'd12, 32'hA3);
      chk("full.pop12.q", 64'(QCOUNT), 64'd0);
      tick();
      chk("full.idle.WE", 64'(WE), 64'd0);

      // scoreboard set/clear, plus same-edge set wins
      AR = 5'd9; BR = 5'd8;
      LD_ISSUE = 1; LD_ISSUE_RD = 5'd9;
      tick();
      LD_ISSUE = 0;
      chk("sb.set.A", 64'(BUSY_A), 64'd1);
      chk("sb.set.B", 64'(BUSY_B), 64'd0);
      LD_VALID = 1; LD_RD = 5'd9; LD_D = 32'h99;
      tick();
      LD_VALID = 0;
      chk("sb.pushed.A", 64'(BUSY_A), 64'd1);
      tick();
      chk_wr("sb.pop9", 1'b1, 5'd9, 32'h99);
      chk("sb.clr.A", 64'(BUSY_A), 64'd0);
      chk("fwd.ld9.A", 64'(FWD_A), 64'(exp_fwd));
      chk("fwd.ld9.B", 64'(FWD_B), 64'd0);
      LD_ISSUE = 1;
      tick();
      LD_ISSUE = 0;
      LD_VALID = 1; LD_D = 32'h98;
      tick();
      LD_VALID = 0;
      LD_ISSUE = 1;
      tick();
      LD_ISSUE = 0;
      chk_wr("sb.same.pop", 1'b1, 5'd9, 32'h98);
      chk("sb.same.A", 64'(BUSY_A), 64'd1);
      LD_VALID = 1; LD_D = 32'h97;
      tick();
      LD_VALID = 0;
      tick();
      chk_wr("sb.final.pop", 1'b1, 5'd9, 32'h97);
      chk("sb.final.A", 64'(BUSY_A), 64'd0);

      // forwarding on AW==AR==BR, never for r0
      AR = 5'd4; BR = 5'd4;
      ALU_VALID = 1; ALU_RD = 5'd4; ALU_D = 32'h44;
      tick();
      chk_wr("fwd.alu4", 1'b1, 5'd4, 32'h44);
      chk("fwd.alu4.A", 64'(FWD_A), 64'(exp_fwd));
      chk("fwd.alu4.B", 64'(FWD_B), 64'(exp_fwd));
      ALU_RD = 5'd0;
      tick();
      ALU_VALID = 0;
      chk("fwd.r0.A", 64'(FWD_A), 64'd0);
      chk("fwd.r0.B", 64'(FWD_B), 64'd0);

      // load to r0 is accepted then dropped
      LD_VALID = 1; LD_RD = 5'd0; LD_D = 32'h55;
      tick();
      LD_VALID = 0;
      chk("ld0.q", 64'(QCOUNT), 64'd1);
      tick();
      chk_wr("ld0.pop", 1'b0, 5'd4, 32'h44);
      chk("ld0.q0", 64'(QCOUNT), 64'd0);

      // asynchronous reset with two loads queued
      AR = 5'd13; BR = 5'd14;
      LD_ISSUE = 1; LD_ISSUE_RD = 5'd13;
      tick();
      LD_ISSUE_RD = 5'd14;
      ALU_VALID = 1; ALU_RD = 5'd3; ALU_D = 32'h33;
      LD_VALID = 1; LD_RD = 5'd13; LD_D = 32'hD13;
      tick();
      LD_ISSUE = 0;
      LD_RD = 5'd14; LD_D = 32'hD14;
      tick();
      LD_VALID = 0;
      chk("rst.pre.q", 64'(QCOUNT), 64'd2);
      chk("rst.pre.A", 64'(BUSY_A), 64'd1);
      chk("rst.pre.B", 64'(BUSY_B), 64'd1);
      ALU_VALID = 0;
      #2 RST_N = 1'b0;
      #1;
      chk_wr("rst.async", 1'b0, 5'd0, 32'h0);
      chk("rst.async.q", 64'(QCOUNT), 64'd0);
      chk("rst.async.rdy", 64'(LD_READY), 64'd1);
      chk("rst.async.A", 64'(BUSY_A), 64'd0);
      chk("rst.async.B", 64'(BUSY_B), 64'd0);
      @(negedge CLK);
      RST_N = 1'b1;
      tick();
      chk("rst.post1.WE", 64'(WE), 64'd0);
      tick();
      chk("rst.post2.WE", 64'(WE), 64'd0);
      chk("rst.post2.q", 64'(QCOUNT), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
